// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with packet locking: grants one of NUM_CLIENTS
// requesters, holds the grant until the last beat, and rotates priority by weight.
module wrr_lock_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int WEIGHT_W    = 4,
  localparam int ENC_W      = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        last,
  input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weight,
  input  logic                          ack,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic                          gnt_valid,
  output logic [ENC_W-1:0]              gnt_id,
  output logic                          busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  localparam logic [ENC_W-1:0] LAST_ID  = ENC_W'(NUM_CLIENTS - 1);
  localparam logic [ENC_W:0]   N_WIDE   = (ENC_W+1)'(NUM_CLIENTS);

  state_t              r_state, w_state_nxt;
  logic [ENC_W-1:0]    r_owner, w_owner_nxt;
  logic [ENC_W-1:0]    r_ptr, w_ptr_nxt;
  logic [WEIGHT_W:0]   r_credit, w_credit_nxt;

  logic [2*NUM_CLIENTS-1:0] w_req2;
  logic [NUM_CLIENTS-1:0]   w_rot;
  logic [ENC_W:0]           w_off;
  logic [ENC_W:0]           w_sum;
  logic                     w_found;
  logic [ENC_W-1:0]         w_winner;

  logic [ENC_W-1:0]         w_sel;
  logic                     w_valid;
  logic [NUM_CLIENTS-1:0]   w_onehot;
  logic                     w_xfer;
  logic                     w_last;
  logic [WEIGHT_W-1:0]      w_weight_sel;
  logic [WEIGHT_W:0]        w_cnt;

  // Rotate requests so bit 0 is the ptr client; the lowest set bit is then the
  // circular winner, and its offset is added back to ptr modulo NUM_CLIENTS.
  always_comb begin
    w_req2  = {req, req} >> r_ptr;
    w_rot   = w_req2[NUM_CLIENTS-1:0];
    w_found = |w_rot;
    w_off   = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = (ENC_W+1)'(k);
    end
    w_sum = {1'b0, r_ptr} + w_off;
    if (w_sum >= N_WIDE) begin
      w_winner = ENC_W'(w_sum - N_WIDE);
    end else begin
      w_winner = w_sum[ENC_W-1:0];
    end
  end

  always_comb begin
    if (r_state == S_LOCKED) begin
      w_sel   = r_owner;
      w_valid = |((NUM_CLIENTS'(1) << r_owner) & req);
    end else begin
      w_sel   = w_winner;
      w_valid = w_found;
    end
    w_onehot     = w_valid ? (NUM_CLIENTS'(1) << w_sel) : '0;
    w_last       = |(w_onehot & last);
    w_xfer       = w_valid && ack;
    w_weight_sel = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (w_sel == ENC_W'(k)) w_weight_sel = weight[k*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign gnt       = rst ? w_onehot : '0;
  assign gnt_valid = rst & w_valid;
  assign gnt_id    = (rst && w_valid) ? w_sel : '0;
  assign busy      = rst && (r_state == S_LOCKED);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path through this
    // block leaves a signal unassigned and infers a latch.
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_credit_nxt = r_credit;
    w_cnt        = (w_sel == r_ptr) ? r_credit + (WEIGHT_W+1)'(1) : (WEIGHT_W+1)'(1);
    if (w_xfer) begin
      if (w_last) begin
        w_state_nxt = S_IDLE;
        if (w_cnt <= {1'b0, w_weight_sel}) begin
          w_ptr_nxt    = w_sel;
          w_credit_nxt = w_cnt;
        end else begin
          w_ptr_nxt    = (w_sel == LAST_ID) ? '0 : w_sel + ENC_W'(1);
          w_credit_nxt = '0;
        end
      end else if (r_state == S_IDLE) begin
        w_state_nxt = S_LOCKED;
        w_owner_nxt = w_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_credit <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_credit <= w_credit_nxt;
    end
  end

endmodule

// File: doc/wrr_lock_arbiter.md
# wrr_lock_arbiter

Parametrised weighted round-robin arbiter with packet locking for the router output ports. It arbitrates NUM_CLIENTS requesters onto one shared output. Once a client wins, the grant stays with it until the packet's last beat is accepted. Each client may take up to weight+1 consecutive packets before priority rotates. It is the generalised successor to the fixed 4-client single-cycle round-robin arbiter: any client count, downstream handshake, multi-beat locking, per-client weights.

## Interface
- NUM_CLIENTS, 4, number of requesters; must be >= 2; need not be a power of 2.
- WEIGHT_W, 4, width of each per-client weight field.
- ENC_W, $clog2(NUM_CLIENTS), localparam, encoded id width.
- clk  input  1  single clock; all state on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = in reset).
- req  input  NUM_CLIENTS  per-client request; bit i means client i has a beat pending.
- last  input  NUM_CLIENTS  bit i marks client i's current beat as the last beat of its packet.
- weight  input  NUM_CLIENTS*WEIGHT_W  client i extra-packet allowance at [i*WEIGHT_W +: WEIGHT_W]; quasi-static; sampled at packet completion.
- ack  input  1  downstream accepts the granted beat this cycle; ignored when gnt_valid=0.
- gnt  output  NUM_CLIENTS  one-hot grant, or all zero.
- gnt_valid  output  1  equals |gnt.
- gnt_id  output  ENC_W  binary index of the granted client; 0 when gnt_valid=0.
- busy  output  1  high while in LOCKED.

## Operation
- Registered state: `state` (IDLE/LOCKED), `owner` (ENC_W), `ptr` (ENC_W, top-priority client), `credit` (WEIGHT_W+1 bits).
- IDLE: winner is the first set bit of req, searching circularly from ptr upward and wrapping NUM_CLIENTS-1 -> 0. The grant is driven combinationally in the same cycle. With no request, gnt=0.
- LOCKED: gnt = one-hot(owner) & req. Other requests are ignored; there is no preemption. If the owner drops req, gnt_valid=0 and the lock is held.
- A beat is transferred when gnt_valid && ack.
- Transfer with last[winner]=0 in IDLE: next state LOCKED, owner <= winner.
- Transfer with last=1 in IDLE or LOCKED completes a packet. Next state is IDLE and the credit update runs for completing client c:
  - cnt = (c==ptr) ? credit+1 : 1.
  - If cnt <= weight[c]: ptr <= c, credit <= cnt.
  - Otherwise: ptr <= (c+1) mod NUM_CLIENTS, credit <= 0.
- Result: weight 0 is plain round-robin; weight k gives client c up to k+1 consecutive packets.
- A single-beat packet (last=1 on the first beat) never enters LOCKED.
- ptr increment wraps at NUM_CLIENTS-1 -> 0 for non-power-of-2 counts. Compare widths are zero-extended.
- Weight changes take effect at the next packet completion only.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, owner=0, ptr=0, credit=0. gnt, gnt_valid, gnt_id and busy are forced 0 while rst=0. Arbitration resumes in the first cycle after release.
- Grant latency in IDLE is 0 cycles from req (combinational path req -> gnt).
- State, owner, ptr and credit update on the clock edge of the transfer and take effect the next cycle.
- Back-to-back packets have no bubble. After a last-beat transfer, IDLE arbitration with the new ptr happens in the very next cycle.
- A ack without gnt_valid has no effect.
- Reset asserted mid-packet abandons the lock. No partial-packet recovery is done.
- Simultaneous new requests while LOCKED are only considered after the owner's last beat.

## Test plan
- Reset/idle: rst=0 with req=4'b1111 -> gnt=0, gnt_id=0, busy=0. Release rst, all weights 0, ack=1, last=1111 -> grants 0,1,2,3,0 on consecutive cycles.
- Lock: req=0011, client 0 sends a 3-beat packet (last on beat 3), ack=1 -> gnt=0001 for 3 cycles, busy=1 on cycles 2-3. Client 1 is granted on cycle 4.
- Owner stall: while LOCKED on client 2, drop req[2] for 2 cycles with req[0]=1 -> gnt=0 for both cycles, busy=1. Re-assert -> gnt=0100 resumes.
- Weights: NUM_CLIENTS=3, weight={0,0,2}, all req=1, single-beat packets, ack=1 -> grant order 0,1,2,2,2,0,1,2,2,2.
- Backpressure: req=0100, ack=0 for 3 cycles then 1, last=1 -> gnt=0100 held all 4 cycles; ptr advances only after the acked cycle.
- Wrap/reset mid-packet: NUM_CLIENTS=5, client 4 wins a single-beat packet -> next top priority is 0. Assert rst during a LOCKED packet -> outputs go 0 immediately; after release, client 0 wins first.
